frame_sum_accumulator: RTL

Multi-channel, frame-aware accumulator that sums per-line sums over a frame of `NUM_LINES` lines and presents one registered result per frame. It replaces the free-running line-sum accumulator. It adds frame delimiting, a line counter, per-channel overflow tracking and valid/ready handshakes on both sides. It sits between the per-line sum stage and the frame-statistics consumer.

---
 rtl/frame_sum_accumulator.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/frame_sum_accumulator.sv
// Frame-aware multi-channel line-sum accumulator with valid/ready on both sides.
// Define FRAME_ACC_SAT_EN to clamp on overflow instead of wrapping.
module frame_sum_accumulator #(
    parameter int NUM_CH       = 1,
    parameter int LINE_SIZE    = 640,
    parameter int PIXEL_SIZE   = 8,
    parameter int NUM_OF_LINES = 480,
    parameter int LINE_SUM_W   = $clog2(LINE_SIZE) + 2 * PIXEL_SIZE,
    parameter int NUM_LINES    = NUM_OF_LINES,
    parameter int ACC_W        = $clog2(NUM_LINES) + LINE_SUM_W
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*LINE_SUM_W-1:0] in_sum,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUM_CH*ACC_W-1:0]      out_sum,
    output logic [$clog2(NUM_LINES+1)-1:0] out_lines,
    output logic [NUM_CH-1:0]            out_ovf,
    output logic                         frame_err
);

    localparam int CNT_W = $clog2(NUM_LINES + 1);
    localparam int SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_HOLD
    } state_e;

    state_e state_q, state_d;

    logic [NUM_CH-1:0][ACC_W-1:0] acc_q, acc_d;
    logic [NUM_CH-1:0][SUM_W-1:0] sum_w;
    logic [NUM_CH-1:0]            ovf_q, ovf_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d, cnt_nxt;
    logic                         pend_q, pend_d;
    logic                         err_q, err_d;

    logic xfer, trunc, hs, start_hs, clr;

    always_comb begin
        xfer     = in_valid && (state_q == S_ACCUM);
        trunc    = frame_start && (state_q == S_ACCUM);
        hs       = out_ready && (state_q == S_HOLD);
        start_hs = pend_q || frame_start;
        clr      = ((state_q == S_IDLE) && frame_start)
                || (hs && start_hs)
                || (trunc && !xfer);
        cnt_nxt  = (trunc ? CNT_W'(0) : cnt_q) + CNT_W'(1);
    end

    // A truncating beat starts from zero, so it is line 0 of the new frame
    always_comb begin
        sum_w = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sum_w[c] = SUM_W'(trunc ? ACC_W'(0) : acc_q[c])
                     + SUM_W'(in_sum[c*LINE_SUM_W +: LINE_SUM_W]);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (xfer && cnt_nxt == CNT_W'(NUM_LINES)) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (hs) state_d = start_hs ? S_ACCUM : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_ACCUM);
        out_valid = (state_q == S_HOLD);
        out_sum   = acc_q;
        out_lines = cnt_q;
        out_ovf   = ovf_q;
        frame_err = err_q;
    end

    always_comb begin
        acc_d  = acc_q;
        ovf_d  = ovf_q;
        cnt_d  = cnt_q;
        pend_d = pend_q;
        err_d  = trunc;
        if (clr) begin
            acc_d = '0;
            ovf_d = '0;
            cnt_d = '0;
        end
        if (xfer) begin
            cnt_d = cnt_nxt;
            for (int c = 0; c < NUM_CH; c++) begin
                ovf_d[c] = (ovf_q[c] && !trunc) || sum_w[c][ACC_W];
`ifdef FRAME_ACC_SAT_EN
                acc_d[c] = ovf_d[c] ? {ACC_W{1'b1}} : sum_w[c][ACC_W-1:0];
`else
                acc_d[c] = sum_w[c][ACC_W-1:0];
`endif
            end
        end
        if (state_q == S_HOLD) begin
            pend_d = hs ? 1'b0 : (pend_q || frame_start);
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

endmodule
